// File: rtl/ahb_mem_pkg.sv
// Shared AHB encodings and FSM state type for the ahb_mem_slv memory slave.
package ahb_mem_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_mem_be_gen.sv
// Byte-lane decode for an AHB transfer: byte enables plus a flag for
// sizes/alignments the backend cannot serve.
module ahb_mem_be_gen
  import ahb_mem_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misaligned
);

  always_comb begin
    be         = '0;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        be         = '1;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_mem_slv.sv
// AHB-to-SRAM-style backend bridge with two-cycle ERROR response for illegal
// transfers. Optional write protection input enabled by AHB_MEM_SLV_WPROT_EN.
module ahb_mem_slv
  import ahb_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 19
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst_b,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef AHB_MEM_SLV_WPROT_EN
  ,
  input  logic              mem_wprot
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [3:0]        be_q, be_d;

  logic [3:0]        be_in;
  logic              misaligned_in;
  logic              illegal;
  logic              phase_open;
  logic              capture;
  logic              unused_haddr_hi;

  ahb_mem_be_gen u_be_gen (
    .hsize      (hsize),
    .addr_lo    (haddr[1:0]),
    .be         (be_in),
    .misaligned (misaligned_in)
  );

  always_comb begin
    unused_haddr_hi = ^haddr[31:ADDR_W];
    phase_open = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                 ((state_q == ST_ACCESS) && mem_ack);
    capture    = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) &&
                 phase_open;
`ifdef AHB_MEM_SLV_WPROT_EN
    illegal    = misaligned_in || (hwrite && mem_wprot);
`else
    illegal    = misaligned_in;
`endif
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      be_q    <= be_d;
    end
  end

  // hsize is held in its decoded byte-lane form; that is all the data phase needs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    be_d    = be_q;
    if (capture) begin
      addr_d  = haddr[ADDR_W-1:2];
      write_d = hwrite;
      be_d    = be_in;
    end
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (capture) state_d = illegal ? ST_ERR1 : ST_ACCESS;
        else         state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          if (capture) state_d = illegal ? ST_ERR1 : ST_ACCESS;
          else         state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hready    = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    mem_addr  = addr_q;
    case (state_q)
      ST_ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_be    = be_q;
        mem_wdata = hwdata;
        hready    = mem_ack;
        if (mem_ack && !write_q) hrdata = mem_rdata;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_mem_slv.sv
// Bench for ahb_mem_slv: transaction-level reference model, per-cycle compare,
// directed literal checks and a randomized pipelined AHB/backend run.
module tb_ahb_mem_slv;

  localparam int unsigned ADDR_W = 19;
`ifdef AHB_MEM_SLV_WPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_b;
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic [1:0]        hresp;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              mem_wprot;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ahb_mem_slv #(.ADDR_W(ADDR_W)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_b),
    .hsel            (hsel),
    .haddr           (haddr),
    .htrans          (htrans),
    .hwrite          (hwrite),
    .hsize           (hsize),
    .hwdata          (hwdata),
    .hrdata          (hrdata),
    .hready          (hready),
    .hresp           (hresp),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack)
`ifdef AHB_MEM_SLV_WPROT_EN
    ,
    .mem_wprot       (mem_wprot)
`endif
  );

  // Transfer currently in its data phase: 0 none, 1 backend access, 2 error response.
  int          dp_kind;
  logic [31:0] dp_addr;
  logic        dp_wr;
  logic [2:0]  dp_size;
  int          dp_wait;
  int          dp_err_left;

  // What the clock edge that ends this cycle must do to the model.
  logic        nx_ready, nx_cap, nx_rst, nx_wr, nx_illegal;
  logic [31:0] nx_addr;
  logic [2:0]  nx_size;
  int          nx_wait;

  bit                chk_en = 1'b0;
  int                exp_kind;
  logic              exp_hready, exp_req, exp_we;
  logic [1:0]        exp_hresp;
  logic [31:0]       exp_hrdata, exp_wdata;
  logic [ADDR_W-3:0] exp_addr;
  logic [3:0]        exp_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit illegal_xfer(input logic [31:0] a, input logic [2:0] s,
                                      input logic w, input logic p);
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && (a % 2) != 0) return 1'b1;
    if (s == 3'd2 && (a % 4) != 0) return 1'b1;
    return PROT_EN && w && p;
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] s);
    int lo;
    lo = int'(a % 4);
    case (s)
      3'd0:    return 4'(1 << lo);
      3'd1:    return (lo >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  // Called just after a rising edge: drives one cycle and publishes expectations.
  task automatic step(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                      input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                      input logic [31:0] rd, input int wait_new, input logic rst_in,
                      input logic prot, input logic junk_ack);
    logic        ack;
    logic [31:0] win;
    ack        = (dp_kind == 1) ? (dp_wait == 0) : junk_ack;
    exp_kind   = dp_kind;
    exp_hready = 1'b1;
    exp_hresp  = 2'b00;
    exp_hrdata = '0;
    exp_req    = 1'b0;
    exp_we     = 1'b0;
    exp_be     = '0;
    exp_wdata  = '0;
    exp_addr   = '0;
    if (dp_kind == 1) begin
      win        = dp_addr & ((32'd1 << ADDR_W) - 32'd1);
      exp_req    = 1'b1;
      exp_we     = dp_wr;
      exp_addr   = (ADDR_W-2)'(win / 4);
      exp_be     = lanes(dp_addr, dp_size);
      exp_wdata  = wd;
      exp_hready = ack;
      if (ack && !dp_wr) exp_hrdata = rd;
    end else if (dp_kind == 2) begin
      exp_hresp  = 2'b01;
      exp_hready = (dp_err_left == 1);
    end
    hsel      = sel & exp_hready;
    htrans    = tr;
    haddr     = addr;
    hwrite    = wr;
    hsize     = sz;
    hwdata    = wd;
    mem_rdata = rd;
    mem_ack   = ack;
    rst_b     = rst_in;
    mem_wprot = prot;
    nx_ready   = exp_hready;
    nx_cap     = hsel && tr[1];
    nx_addr    = addr;
    nx_wr      = wr;
    nx_size    = sz;
    nx_wait    = wait_new;
    nx_rst     = rst_in;
    nx_illegal = illegal_xfer(addr, sz, wr, prot);
    chk_en     = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!nx_rst) begin
      dp_kind = 0;
    end else if (nx_ready) begin
      if (nx_cap) begin
        dp_addr = nx_addr;
        dp_wr   = nx_wr;
        dp_size = nx_size;
        if (nx_illegal) begin
          dp_kind     = 2;
          dp_err_left = 2;
        end else begin
          dp_kind = 1;
          dp_wait = nx_wait;
        end
      end else begin
        dp_kind = 0;
      end
    end else if (dp_kind == 1) begin
      dp_wait--;
    end else if (dp_kind == 2) begin
      dp_err_left--;
    end
    #1;
  endtask

  task automatic xfer(input logic sel, input logic [31:0] addr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] rd,
                      input int wait_new);
    step(sel, 2'b10, addr, wr, sz, wd, rd, wait_new, 1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("hready", 32'(hready), 32'(exp_hready));
      check("hresp", 32'(hresp), 32'(exp_hresp));
      check("hrdata", hrdata, exp_hrdata);
      check("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_kind == 1) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_be", 32'(mem_be), 32'(exp_be));
        check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hsize = 3'd0; hwdata = '0; mem_rdata = '0; mem_ack = 1'b0; mem_wprot = 1'b0;
    dp_kind = 0; dp_addr = '0; dp_wr = 1'b0; dp_size = 3'd0; dp_wait = 0; dp_err_left = 0;
    nx_ready = 1'b1; nx_cap = 1'b0; nx_rst = 1'b1; nx_wr = 1'b0; nx_illegal = 1'b0;
    nx_addr = '0; nx_size = 3'd0; nx_wait = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hready", 32'(hready), 32'd1);
    check("reset_hresp", 32'(hresp), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_hrdata", hrdata, 32'd0);

    // Word read at 0x100, zero wait
    xfer(1'b1, 32'h100, 1'b0, 3'd2, 32'h0, 32'h0, 0);
    advance();
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'hDEADBEEF, 0);
    check("d38_hready", 32'(hready), 32'd1);
    check("d38_hrdata", hrdata, 32'hDEADBEEF);
    check("d38_hresp", 32'(hresp), 32'd0);
    check("d38_be", 32'(mem_be), 32'hF);
    check("d38_addr", 32'(mem_addr), 32'h40);
    advance();

    // Byte write at 0x003, ack after three wait cycles
    xfer(1'b1, 32'h3, 1'b1, 3'd0, 32'h0, 32'h0, 3);
    advance();
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'hAA000000, 32'h0, 0);
      check("d39_hready_low", 32'(hready), 32'd0);
      check("d39_be", 32'(mem_be), 32'h8);
      check("d39_we", 32'(mem_we), 32'd1);
      advance();
    end
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'hAA000000, 32'h0, 0);
    check("d39_hready_done", 32'(hready), 32'd1);
    check("d39_wdata", mem_wdata, 32'hAA000000);
    advance();

    // Misaligned half-word read
    xfer(1'b1, 32'h1, 1'b0, 3'd1, 32'h0, 32'h0, 0);
    advance();
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 0);
    check("d40_e1_hready", 32'(hready), 32'd0);
    check("d40_e1_hresp", 32'(hresp), 32'd1);
    check("d40_e1_req", 32'(mem_req), 32'd0);
    advance();
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 0);
    check("d40_e2_hready", 32'(hready), 32'd1);
    check("d40_e2_hresp", 32'(hresp), 32'd1);
    check("d40_e2_req", 32'(mem_req), 32'd0);
    advance();

    // Back-to-back zero-wait reads
    xfer(1'b1, 32'h0, 1'b0, 3'd2, 32'h0, 32'h0, 0);
    advance();
    xfer(1'b1, 32'h4, 1'b0, 3'd2, 32'h0, 32'h11112222, 0);
    check("d41_a_hready", 32'(hready), 32'd1);
    check("d41_a_addr", 32'(mem_addr), 32'd0);
    advance();
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h33334444, 0);
    check("d41_b_hready", 32'(hready), 32'd1);
    check("d41_b_addr", 32'(mem_addr), 32'd1);
    check("d41_b_hrdata", hrdata, 32'h33334444);
    advance();

    // Reset during the second ACCESS cycle
    xfer(1'b1, 32'h10, 1'b0, 3'd2, 32'h0, 32'h0, 3);
    advance();
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 0);
    advance();
    step(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    check("d42_req_before", 32'(mem_req), 32'd1);
    advance();
    step(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b1);
    check("d42_req", 32'(mem_req), 32'd0);
    check("d42_hready", 32'(hready), 32'd1);
    check("d42_hresp", 32'(hresp), 32'd0);
    advance();

`ifdef AHB_MEM_SLV_WPROT_EN
    // Protected word write
    step(1'b1, 2'b10, 32'h8, 1'b1, 3'd2, 32'h0, 32'h0, 0, 1'b1, 1'b1, 1'b0);
    advance();
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 0);
    check("d43_e1_hready", 32'(hready), 32'd0);
    check("d43_e1_hresp", 32'(hresp), 32'd1);
    check("d43_e1_req", 32'(mem_req), 32'd0);
    advance();
    xfer(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 0);
    check("d43_e2_hready", 32'(hready), 32'd1);
    check("d43_e2_hresp", 32'(hresp), 32'd1);
    check("d43_e2_req", 32'(mem_req), 32'd0);
    advance();
`endif

    for (int i = 0; i < 2000; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      sz = (($urandom % 8) < 6) ? 3'($urandom % 3) : 3'($urandom % 8);
      a  = $urandom;
      if (sz <= 3'd2 && ($urandom % 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      step(($urandom % 4) != 0, 2'($urandom), a, 1'($urandom), sz, $urandom, $urandom,
           int'($urandom % 4), ($urandom % 64) != 0, ($urandom % 4) == 0, 1'($urandom));
      advance();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
